fetch_unit: RTL and testbench

Program-counter and fetch sequencer sitting directly upstream of the control decoder. It drives the instruction ROM address and consumes the decoder's JumpEqual, JumpNotEqual and Ack outputs plus the ALU equal flag. It computes the next PC and sequences program start, run and halt through a Start/Done handshake with the test harness. Jump targets come from a small lookup table indexed by low instruction bits.

---
 rtl/fetch_unit_pkg.sv | 34 +++
 rtl/fetch_unit_if.sv | 33 +++
 rtl/fetch_unit_jump_lut.sv | 17 +
 rtl/fetch_unit.sv | 81 ++++++++
 tb/tb_fetch_unit.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_pkg
// Description : Shared widths, fetch FSM state type and jump-target table.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

  localparam int PC_W   = 10;
  localparam int TIDX_W = 4;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } fetch_state_t;

  // Assembled alongside the program set; the assembler reads the same table.
  localparam logic [PC_W-1:0] kJumpTargets [2**TIDX_W] = '{
    10'h000, 10'h010, 10'h080, 10'h120,
    10'h200, 10'h0A6, 10'h300, 10'h3FF,
    10'h001, 10'h055, 10'h155, 10'h2AA,
    10'h0F0, 10'h1F0, 10'h2F0, 10'h3F0
  };

  // je and jne together cover both flag outcomes, so the jump is unconditional.
  function automatic logic jump_taken(input logic je, input logic jne, input logic eq);
    return (je & eq) | (jne & ~eq);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Harness/decoder-facing bundle of the fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic              Start;
  logic [PC_W-1:0]   StartAddr;
  logic              JumpEqual;
  logic              JumpNotEqual;
  logic              EqualFlag;
  logic [TIDX_W-1:0] TargetIdx;
  logic              Ack;
  logic [PC_W-1:0]   ProgCtr;
  logic              InstValid;
  logic              Done;
  logic [CNT_W-1:0]  CycleCnt;

  modport master (
    output Start, StartAddr, JumpEqual, JumpNotEqual, EqualFlag, TargetIdx, Ack,
    input  ProgCtr, InstValid, Done, CycleCnt
  );

  modport slave (
    input  Start, StartAddr, JumpEqual, JumpNotEqual, EqualFlag, TargetIdx, Ack,
    output ProgCtr, InstValid, Done, CycleCnt
  );

endinterface
`default_nettype wire

// File: rtl/fetch_unit_jump_lut.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_jump_lut
// Description : Combinational jump-target lookup (jump_lut) over kJumpTargets.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit_jump_lut
  import fetch_unit_pkg::*;
(
  input  wire logic [TIDX_W-1:0] i_idx,
  output logic      [PC_W-1:0]   o_target
);

  assign o_target = kJumpTargets[i_idx];

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Program counter and IDLE/LOAD/RUN/HALT fetch sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  wire logic   Clk,
  input  wire logic   Reset,
  fetch_unit_if.slave bus
);

  fetch_state_t     r_state, w_state_nxt;
  logic [PC_W-1:0]  r_pc, w_pc_nxt, w_target;
  logic             r_done, w_done_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  fetch_unit_jump_lut u_jump_lut (
    .i_idx    (bus.TargetIdx),
    .o_target (w_target)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_done  <= w_done_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_done_nxt  = r_done;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (bus.Start) w_state_nxt = LOAD;
      end
      LOAD: begin
        w_done_nxt = 1'b0;
        w_cnt_nxt  = '0;
        if (bus.Start) w_pc_nxt = bus.StartAddr;
        else           w_state_nxt = RUN;
      end
      RUN: begin
        if (r_cnt != {CNT_W{1'b1}}) w_cnt_nxt = r_cnt + 1'b1;
        // Restart outranks halt, halt outranks jump, jump outranks increment.
        if (bus.Start) begin
          w_state_nxt = LOAD;
        end else if (bus.Ack) begin
          w_state_nxt = HALT;
          w_done_nxt  = 1'b1;
        end else if (jump_taken(bus.JumpEqual, bus.JumpNotEqual, bus.EqualFlag)) begin
          w_pc_nxt = w_target;
        end else begin
          w_pc_nxt = r_pc + 1'b1;
        end
      end
      HALT: begin
        if (bus.Start) w_state_nxt = LOAD;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.ProgCtr   = r_pc;
  assign bus.InstValid = (r_state == RUN);
  assign bus.Done      = r_done;
  assign bus.CycleCnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Scoreboard bench for fetch_unit with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic Clk;
  logic Reset;

  fetch_unit_if bus ();

  fetch_unit dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [9:0]  pc;
    logic        v;
    logic        d;
    logic [15:0] cnt;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input exp_t e);
    tests++;
    if (bus.ProgCtr !== e.pc || bus.InstValid !== e.v ||
        bus.Done !== e.d || bus.CycleCnt !== e.cnt) begin
      fails++;
      $display("FAIL %s: got pc=%h valid=%b done=%b cnt=%h, want pc=%h valid=%b done=%b cnt=%h",
               e.name, bus.ProgCtr, bus.InstValid, bus.Done, bus.CycleCnt,
               e.pc, e.v, e.d, e.cnt);
    end
  endtask

  // Monitor: results of an edge are compared 3 time units after that edge.
  always @(posedge Clk) begin
    #3;
    if (sbq.size() > 0) check(sbq.pop_front());
  end

  task automatic cyc(input logic st, input logic [9:0] sa,
                     input logic je, input logic jne, input logic eq,
                     input logic [3:0] ti, input logic ack,
                     input bit push, input logic [9:0] pc, input logic v,
                     input logic d, input logic [15:0] c, input string nm);
    exp_t e;
    @(negedge Clk);
    bus.Start        = st;
    bus.StartAddr    = sa;
    bus.JumpEqual    = je;
    bus.JumpNotEqual = jne;
    bus.EqualFlag    = eq;
    bus.TargetIdx    = ti;
    bus.Ack          = ack;
    if (push) begin
      e.pc = pc; e.v = v; e.d = d; e.cnt = c; e.name = nm;
      sbq.push_back(e);
    end
  endtask

  task automatic direct(input logic [9:0] pc, input logic v, input logic d,
                        input logic [15:0] c, input string nm);
    exp_t e;
    e.pc = pc; e.v = v; e.d = d; e.cnt = c; e.name = nm;
    check(e);
  endtask

  initial begin
    Reset = 1'b1;
    bus.Start = 1'b0; bus.StartAddr = '0; bus.JumpEqual = 1'b0;
    bus.JumpNotEqual = 1'b0; bus.EqualFlag = 1'b0; bus.TargetIdx = '0; bus.Ack = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    #1 direct(10'h000, 0, 0, 16'h0000, "reset");

    //  st  sa      je jne eq ti  ack push pc     v  d  cnt
    cyc(0, 10'h040, 0, 0, 0, 4'd0, 0, 1, 10'h000, 0, 0, 16'd0, "idle_hold");
    cyc(1, 10'h040, 0, 0, 0, 4'd0, 0, 1, 10'h000, 0, 0, 16'd0, "idle_to_load");
    cyc(1, 10'h040, 0, 0, 0, 4'd0, 0, 1, 10'h040, 0, 0, 16'd0, "load");
    cyc(1, 10'h040, 1, 1, 1, 4'd3, 1, 1, 10'h040, 0, 0, 16'd0, "load_ignores_dec");
    cyc(0, 10'h040, 0, 0, 0, 4'd0, 0, 1, 10'h040, 1, 0, 16'd0, "run_entry");
    cyc(0, 10'h040, 0, 0, 0, 4'd0, 0, 1, 10'h041, 1, 0, 16'd1, "seq1");
    cyc(0, 10'h040, 0, 0, 0, 4'd0, 0, 1, 10'h042, 1, 0, 16'd2, "seq2");
    cyc(0, 10'h040, 0, 0, 0, 4'd0, 0, 1, 10'h043, 1, 0, 16'd3, "seq3");
    cyc(0, 10'h040, 0, 0, 0, 4'd0, 0, 1, 10'h044, 1, 0, 16'd4, "seq4");
    cyc(0, 10'h040, 0, 0, 0, 4'd0, 0, 1, 10'h045, 1, 0, 16'd5, "seq5");
    cyc(0, 10'h040, 1, 0, 1, 4'd3, 0, 1, 10'h120, 1, 0, 16'd6, "je_taken");
    cyc(0, 10'h040, 1, 0, 0, 4'd3, 0, 1, 10'h121, 1, 0, 16'd7, "je_not_taken");
    cyc(0, 10'h040, 0, 1, 0, 4'd3, 0, 1, 10'h120, 1, 0, 16'd8, "jne_taken");
    cyc(0, 10'h040, 0, 1, 1, 4'd3, 0, 1, 10'h121, 1, 0, 16'd9, "jne_not_taken");
    cyc(0, 10'h040, 1, 1, 0, 4'd5, 0, 1, 10'h0A6, 1, 0, 16'd10, "both_uncond");
    cyc(0, 10'h040, 0, 0, 0, 4'd0, 0, 1, 10'h0A7, 1, 0, 16'd11, "inc");
    cyc(0, 10'h040, 1, 0, 1, 4'd3, 1, 1, 10'h0A7, 0, 1, 16'd12, "ack_beats_jump");
    cyc(0, 10'h040, 1, 1, 1, 4'd3, 1, 1, 10'h0A7, 0, 1, 16'd12, "halt_frozen");
    cyc(1, 10'h3FE, 0, 0, 0, 4'd0, 0, 1, 10'h0A7, 0, 1, 16'd12, "halt_to_load");
    cyc(1, 10'h3FE, 0, 0, 0, 4'd0, 0, 1, 10'h3FE, 0, 0, 16'd0, "load_clears_done");
    cyc(0, 10'h3FE, 0, 0, 0, 4'd0, 0, 1, 10'h3FE, 1, 0, 16'd0, "run2");
    cyc(0, 10'h3FE, 0, 0, 0, 4'd0, 0, 1, 10'h3FF, 1, 0, 16'd1, "pc_max");
    cyc(0, 10'h3FE, 0, 0, 0, 4'd0, 0, 1, 10'h000, 1, 0, 16'd2, "pc_wrap");
    cyc(1, 10'h010, 1, 0, 1, 4'd3, 0, 0, 10'h000, 0, 0, 16'd0, "");
    cyc(1, 10'h010, 0, 0, 0, 4'd0, 0, 1, 10'h010, 0, 0, 16'd0, "restart_no_jump");
    cyc(0, 10'h010, 0, 0, 0, 4'd0, 0, 1, 10'h010, 1, 0, 16'd0, "restart_run");
    cyc(0, 10'h010, 0, 0, 0, 4'd0, 0, 1, 10'h011, 1, 0, 16'd1, "rseq1");
    cyc(0, 10'h010, 0, 0, 0, 4'd0, 0, 1, 10'h012, 1, 0, 16'd2, "rseq2");
    cyc(0, 10'h010, 0, 0, 0, 4'd0, 0, 1, 10'h013, 1, 0, 16'd3, "rseq3");
    cyc(0, 10'h010, 0, 0, 0, 4'd0, 0, 1, 10'h014, 1, 0, 16'd4, "rseq4");
    cyc(0, 10'h010, 0, 0, 0, 4'd0, 0, 1, 10'h015, 1, 0, 16'd5, "rseq5");

    // Asynchronous reset in the middle of a RUN cycle.
    @(negedge Clk);
    #1 Reset = 1'b1;
    #1 direct(10'h000, 0, 0, 16'h0000, "reset_mid_run");
    #1 Reset = 1'b0;

    cyc(1, 10'h040, 0, 0, 0, 4'd0, 0, 1, 10'h000, 0, 0, 16'd0, "post_reset_load");
    cyc(1, 10'h040, 0, 0, 0, 4'd0, 0, 1, 10'h040, 0, 0, 16'd0, "post_reset_addr");
    cyc(0, 10'h040, 0, 0, 0, 4'd0, 0, 1, 10'h040, 1, 0, 16'd0, "post_reset_run");

    for (int i = 0; i < 70000; i++) begin
      if (i == 65533)
        cyc(0, 10'h040, 0, 0, 0, 4'd0, 0, 1, 10'h03E, 1, 0, 16'hFFFE, "cnt_near_max");
      else if (i == 65534)
        cyc(0, 10'h040, 0, 0, 0, 4'd0, 0, 1, 10'h03F, 1, 0, 16'hFFFF, "cnt_max");
      else if (i == 69999)
        cyc(0, 10'h040, 0, 0, 0, 4'd0, 0, 1, 10'h1B0, 1, 0, 16'hFFFF, "cnt_saturated");
      else
        cyc(0, 10'h040, 0, 0, 0, 4'd0, 0, 0, 10'h000, 0, 0, 16'd0, "");
    end
    cyc(0, 10'h040, 0, 0, 0, 4'd0, 0, 1, 10'h1B1, 1, 0, 16'hFFFF, "sat_no_wrap");
    cyc(0, 10'h040, 0, 0, 0, 4'd0, 1, 1, 10'h1B1, 0, 1, 16'hFFFF, "halt_saturated");

    repeat (2) @(posedge Clk);
    #5;
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
